binary_searcher: RTL

BINARY_SEARCHER -- requirements
Module: binary_searcher

---
 rtl/binary_searcher.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/binary_searcher.sv
// Binary search driver for an external comparator: one probe per COMPARE cycle, at most N+1 probes.
// Latency: start -> first probe next cycle; o_done pulses the cycle after the final compare.
module binary_searcher #(
   parameter int N = 4
) (
   input  logic         i_clock,
   input  logic         i_reset_n,
   input  logic         i_start,
   output logic [N-1:0] o_probe,
   input  logic         i_greater,
   input  logic         i_equal,
   input  logic         i_less,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_found,
   output logic         o_error,
   output logic [N-1:0] o_result,
   output logic [N-1:0] o_steps
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [N-1:0] MaxVal = {N{1'b1}};

   state_t       state_q, state_d;
   logic [N-1:0] low_q, low_d;
   logic [N-1:0] high_q, high_d;
   logic [N-1:0] mid_q, mid_d;
   logic [N-1:0] result_q, result_d;
   logic [N-1:0] steps_q, steps_d;
   logic         found_q, found_d;
   logic         error_q, error_d;

   logic         flags_onehot;
   logic [N-1:0] new_high;
   logic [N-1:0] new_low;

   // Sum is widened by one bit so low+high never wraps.
   function automatic logic [N-1:0] midpoint(input logic [N-1:0] lo, input logic [N-1:0] hi);
      logic [N:0] sum;
      sum = {1'b0, lo} + {1'b0, hi};
      return sum[N:1];
   endfunction

   assign flags_onehot = ({i_greater, i_equal, i_less} == 3'b100) ||
                         ({i_greater, i_equal, i_less} == 3'b010) ||
                         ({i_greater, i_equal, i_less} == 3'b001);
   assign new_high = mid_q - 1'b1;
   assign new_low  = mid_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      low_d    = low_q;
      high_d   = high_q;
      mid_d    = mid_q;
      result_d = result_q;
      steps_d  = steps_q;
      found_d  = found_q;
      error_d  = error_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               low_d   = '0;
               high_d  = MaxVal;
               mid_d   = midpoint('0, MaxVal);
               found_d = 1'b0;
               error_d = 1'b0;
               steps_d = '0;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            steps_d = steps_q + 1'b1;
            if (!flags_onehot) begin
               error_d  = 1'b1;
               result_d = mid_q;
               state_d  = DONE;
            end else if (i_equal) begin
               found_d  = 1'b1;
               result_d = mid_q;
               state_d  = DONE;
            end else if (i_greater) begin
               // mid==0 or an emptied range means the flags contradict earlier ones.
               if (mid_q == '0 || new_high < low_q) begin
                  error_d  = 1'b1;
                  result_d = mid_q;
                  state_d  = DONE;
               end else begin
                  high_d = new_high;
                  mid_d  = midpoint(low_q, new_high);
               end
            end else begin
               if (mid_q == MaxVal || new_low > high_q) begin
                  error_d  = 1'b1;
                  result_d = mid_q;
                  state_d  = DONE;
               end else begin
                  low_d = new_low;
                  mid_d = midpoint(new_low, high_q);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= IDLE;
         low_q    <= '0;
         high_q   <= '0;
         mid_q    <= '0;
         result_q <= '0;
         steps_q  <= '0;
         found_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         low_q    <= low_d;
         high_q   <= high_d;
         mid_q    <= mid_d;
         result_q <= result_d;
         steps_q  <= steps_d;
         found_q  <= found_d;
         error_q  <= error_d;
      end
   end

   assign o_probe  = mid_q;
   assign o_busy   = (state_q == COMPARE);
   assign o_done   = (state_q == DONE);
   assign o_found  = found_q;
   assign o_error  = error_q;
   assign o_result = result_q;
   assign o_steps  = steps_q;

endmodule
